// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_pkg
// Purpose  : Shared types, layer codes and tap-count helper for the MAC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CAPT  = 3'd4,
        ST_EMIT  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam logic [2:0] LAYER_CONV0 = 3'd0;
    localparam logic [2:0] LAYER_CONV1 = 3'd1;
    localparam logic [2:0] LAYER_FC    = 3'd2;

    localparam int CONV_TAPS   = 25;
    localparam int FC_TAPS_DEF = 192;
    localparam int TAP_W       = 10;

    function automatic logic layer_legal(input logic [2:0] layer);
        return (layer <= LAYER_FC);
    endfunction

    function automatic logic [TAP_W-1:0] tap_count(input logic [2:0] layer, input int fc_taps);
        return (layer == LAYER_FC) ? TAP_W'(fc_taps) : TAP_W'(CONV_TAPS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_ctrl_if
// Purpose  : SRAM read bus, MAC operand/control bus and result handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface mac_seq_ctrl_if #(
    parameter int AW = 12
);
    logic          rd_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] a_addr;
    logic [15:0]   w_rdata;
    logic [15:0]   a_rdata;
    logic [15:0]   mac_a;
    logic [15:0]   mac_b;
    logic          mac_en;
    logic          mac_clr;
    logic [31:0]   mac_acc;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_data;
    logic [9:0]    res_idx;

    modport master (
        output rd_en, w_addr, a_addr, mac_a, mac_b, mac_en, mac_clr,
               res_valid, res_data, res_idx,
        input  w_rdata, a_rdata, mac_acc, res_ready
    );

    modport slave (
        input  rd_en, w_addr, a_addr, mac_a, mac_b, mac_en, mac_clr,
               res_valid, res_data, res_idx,
        output w_rdata, a_rdata, mac_acc, res_ready
    );
endinterface
`default_nettype wire

// File: rtl/mac_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : mac_addr_gen
// Purpose  : Tap/window counters and weight/activation address generation.
// Revision : 1.0 - initial release
// ============================================================================
module mac_addr_gen
    import mac_seq_pkg::*;
#(
    parameter int AW      = 12,
    parameter int FC_TAPS = FC_TAPS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pass_start_i,
    input  logic             tap_clr_i,
    input  logic             tap_step_i,
    input  logic             out_step_i,
    input  logic             is_fc_i,
    input  logic [5:0]       in_w_i,
    input  logic [TAP_W-1:0] taps_i,
    output logic             tap_last_o,
    output logic [AW-1:0]    w_addr_o,
    output logic [AW-1:0]    a_addr_o
);
    logic [TAP_W-1:0] tap_q;
    logic [2:0]       kx_q;
    logic [AW-1:0]    win_row_q;
    logic [5:0]       ocol_q;
    logic [AW-1:0]    row_base_q;
    logic [AW-1:0]    fc_base_q;

    // win_row_q = ky*in_w and row_base_q = orow*in_w, both kept by repeated adds
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_q      <= '0;
            kx_q       <= '0;
            win_row_q  <= '0;
            ocol_q     <= '0;
            row_base_q <= '0;
            fc_base_q  <= '0;
        end else begin
            if (pass_start_i) begin
                ocol_q     <= '0;
                row_base_q <= '0;
                fc_base_q  <= '0;
            end else if (out_step_i) begin
                if (ocol_q == in_w_i - 6'd5) begin
                    ocol_q     <= '0;
                    row_base_q <= row_base_q + AW'(in_w_i);
                end else begin
                    ocol_q <= ocol_q + 6'd1;
                end
                fc_base_q <= fc_base_q + AW'(FC_TAPS);
            end

            if (tap_clr_i) begin
                tap_q     <= '0;
                kx_q      <= '0;
                win_row_q <= '0;
            end else if (tap_step_i) begin
                tap_q <= tap_q + TAP_W'(1);
                if (kx_q == 3'd4) begin
                    kx_q      <= '0;
                    win_row_q <= win_row_q + AW'(in_w_i);
                end else begin
                    kx_q <= kx_q + 3'd1;
                end
            end
        end
    end

    assign tap_last_o = (tap_q == taps_i - TAP_W'(1));
    assign w_addr_o   = is_fc_i ? (fc_base_q + AW'(tap_q)) : AW'(tap_q);
    assign a_addr_o   = is_fc_i ? AW'(tap_q)
                                : (row_base_q + AW'(ocol_q) + win_row_q + AW'(kx_q));

endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_ctrl
// Purpose  : Layer sequencer driving SRAM reads, MAC operands and result port.
// Revision : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int AW      = 12,
    parameter int RD_LAT  = 1,
    parameter int FC_TAPS = FC_TAPS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  layer,
    input  logic [9:0]  cfg_n_out,
    input  logic [5:0]  cfg_in_w,
    output logic        busy,
    output logic        done,
    output logic        err,
    mac_seq_ctrl_if.master bus
);
    localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT + 1);

    state_e           state_q, state_d;
    logic [9:0]       n_out_q, out_idx_q;
    logic [5:0]       in_w_q;
    logic             is_fc_q;
    logic [TAP_W-1:0] taps_q;
    logic [2:0]       drain_cnt_q;
    logic [RD_LAT-1:0] vld_q;
    logic [15:0]      mac_a_q, mac_b_q;
    logic             mac_en_q;
    logic             res_valid_q;
    logic [31:0]      res_data_q;
    logic [9:0]       res_idx_q;
    logic             done_q, err_q;

    logic          w_pass_start, w_tap_clr, w_tap_step, w_out_step, w_capt, w_accept;
    logic          w_tap_last, w_rd_en, w_last;
    logic [AW-1:0] w_w_addr, w_a_addr;

    assign w_rd_en = (state_q == ST_FETCH);
    assign w_last  = (out_idx_q == n_out_q - 10'd1);

    always_comb begin
        state_d      = state_q;
        w_pass_start = 1'b0;
        w_tap_clr    = 1'b0;
        w_tap_step   = 1'b0;
        w_out_step   = 1'b0;
        w_capt       = 1'b0;
        w_accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && layer_legal(layer)) begin
                    w_pass_start = 1'b1;
                    state_d      = (cfg_n_out == 10'd0) ? ST_DONE : ST_CLR;
                end
            end
            ST_CLR: begin
                w_tap_clr = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_FETCH: begin
                w_tap_step = 1'b1;
                if (w_tap_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) state_d = ST_CAPT;
            end
            ST_CAPT: begin
                w_capt  = 1'b1;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (bus.res_ready) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        state_d = ST_DONE;
                    end else begin
                        w_out_step = 1'b1;
                        state_d    = ST_CLR;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            n_out_q     <= '0;
            out_idx_q   <= '0;
            in_w_q      <= '0;
            is_fc_q     <= 1'b0;
            taps_q      <= '0;
            drain_cnt_q <= '0;
            vld_q       <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_DONE);
            err_q   <= (state_q == ST_IDLE) && start && !layer_legal(layer);

            if (w_pass_start) begin
                n_out_q   <= cfg_n_out;
                in_w_q    <= cfg_in_w;
                is_fc_q   <= (layer == LAYER_FC);
                taps_q    <= tap_count(layer, FC_TAPS);
                out_idx_q <= '0;
            end else if (w_out_step) begin
                out_idx_q <= out_idx_q + 10'd1;
            end

            drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + 3'd1 : 3'd0;

            // rd_en delayed by the SRAM latency marks the cycle read data is valid
            vld_q[0] <= w_rd_en;
            for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
            mac_en_q <= vld_q[RD_LAT-1];
            if (vld_q[RD_LAT-1]) begin
                mac_a_q <= bus.a_rdata;
                mac_b_q <= bus.w_rdata;
            end

            if (w_capt) begin
                res_valid_q <= 1'b1;
                res_data_q  <= bus.mac_acc;
                res_idx_q   <= out_idx_q;
            end else if (w_accept) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    mac_addr_gen #(
        .AW      (AW),
        .FC_TAPS (FC_TAPS)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .pass_start_i (w_pass_start),
        .tap_clr_i    (w_tap_clr),
        .tap_step_i   (w_tap_step),
        .out_step_i   (w_out_step),
        .is_fc_i      (is_fc_q),
        .in_w_i       (in_w_q),
        .taps_i       (taps_q),
        .tap_last_o   (w_tap_last),
        .w_addr_o     (w_w_addr),
        .a_addr_o     (w_a_addr)
    );

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign bus.rd_en     = w_rd_en;
    assign bus.w_addr    = w_rd_en ? w_w_addr : '0;
    assign bus.a_addr    = w_rd_en ? w_a_addr : '0;
    assign bus.mac_clr   = (state_q == ST_CLR);
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_seq_ctrl
// Purpose  : Directed bench for mac_seq_ctrl with SRAM and MAC models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0, start2 = 1'b0;
    logic [2:0] layer = 3'd0;
    logic [9:0] cfg_n_out = 10'd0;
    logic [5:0] cfg_in_w = 6'd0;
    logic       busy1, done1, err1, busy2, done2, err2;

    int total = 0;
    int bad   = 0;

    logic [15:0] wmem [0:4095];
    logic [15:0] amem [0:4095];

    mac_seq_ctrl_if #(.AW(12)) if1 ();
    mac_seq_ctrl_if #(.AW(12)) if2 ();

    mac_seq_ctrl #(.AW(12), .RD_LAT(1), .FC_TAPS(192)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .layer(layer),
        .cfg_n_out(cfg_n_out), .cfg_in_w(cfg_in_w),
        .busy(busy1), .done(done1), .err(err1), .bus(if1.master)
    );

    mac_seq_ctrl #(.AW(12), .RD_LAT(2), .FC_TAPS(192)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .layer(layer),
        .cfg_n_out(cfg_n_out), .cfg_in_w(cfg_in_w),
        .busy(busy2), .done(done2), .err(err2), .bus(if2.master)
    );

    always #5 clk = ~clk;

    // SRAM models: latency 1 for dut1, latency 2 for dut2
    logic [15:0] w1_q = '0, a1_q = '0, w2a_q = '0, a2a_q = '0, w2b_q = '0, a2b_q = '0;
    always @(posedge clk) begin
        if (if1.rd_en) begin
            w1_q <= wmem[if1.w_addr];
            a1_q <= amem[if1.a_addr];
        end
        if (if2.rd_en) begin
            w2a_q <= wmem[if2.w_addr];
            a2a_q <= amem[if2.a_addr];
        end
        w2b_q <= w2a_q;
        a2b_q <= a2a_q;
    end
    assign if1.w_rdata = w1_q;
    assign if1.a_rdata = a1_q;
    assign if2.w_rdata = w2b_q;
    assign if2.a_rdata = a2b_q;

    logic signed [31:0] acc1 = '0, acc2 = '0;
    always @(posedge clk) begin
        if (reset || if1.mac_clr) acc1 <= '0;
        else if (if1.mac_en) acc1 <= acc1 + $signed(if1.mac_a) * $signed(if1.mac_b);
        if (reset || if2.mac_clr) acc2 <= '0;
        else if (if2.mac_en) acc2 <= acc2 + $signed(if2.mac_a) * $signed(if2.mac_b);
    end
    assign if1.mac_acc = acc1;
    assign if2.mac_acc = acc2;

    int done_cnt1 = 0, rd_cnt1 = 0, en_cnt1 = 0, fa_n1 = 0;
    int done_cnt2 = 0, en_cnt2 = 0;
    logic rd_prev1 = 1'b0;
    logic [11:0] fa1 [0:63];
    logic [11:0] fw1 [0:63];
    always @(posedge clk) begin
        if (done1) done_cnt1 <= done_cnt1 + 1;
        if (done2) done_cnt2 <= done_cnt2 + 1;
        if (if1.rd_en) rd_cnt1 <= rd_cnt1 + 1;
        if (if1.mac_clr) en_cnt1 <= 0;
        else if (if1.mac_en) en_cnt1 <= en_cnt1 + 1;
        if (if2.mac_clr) en_cnt2 <= 0;
        else if (if2.mac_en) en_cnt2 <= en_cnt2 + 1;
        if (if1.rd_en && !rd_prev1) begin
            fa1[fa_n1 % 64] <= if1.a_addr;
            fw1[fa_n1 % 64] <= if1.w_addr;
            fa_n1 <= fa_n1 + 1;
        end
        rd_prev1 <= if1.rd_en;
    end

    task automatic pulse_start(input int which);
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic accept(input int which);
        if (which == 1) if1.res_ready = 1'b1; else if2.res_ready = 1'b1;
        @(negedge clk);
        if1.res_ready = 1'b0;
        if2.res_ready = 1'b0;
    endtask

    task automatic wait_valid(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            if ((which == 1) ? if1.res_valid : if2.res_valid) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_done(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if ((which == 1) ? done1 : done2) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 64; i++) amem[i] = 16'd1;
        for (int i = 0; i < 25; i++) wmem[i] = 16'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy1, done1, err1, if1.rd_en, if1.mac_en, if1.mac_clr, if1.res_valid} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0000000",
                     {busy1, done1, err1, if1.rd_en, if1.mac_en, if1.mac_clr, if1.res_valid});
        end
        total++;
        if ({if1.w_addr, if1.a_addr, if1.mac_a, if1.mac_b, if1.res_data, if1.res_idx} !== '0) begin
            bad++;
            $display("FAIL reset_data got w=%h a=%h ma=%h mb=%h rd=%h ri=%h exp=0", if1.w_addr,
                     if1.a_addr, if1.mac_a, if1.mac_b, if1.res_data, if1.res_idx);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got busy1=%b busy2=%b exp=0", busy1, busy2);
        end
    endtask

    task automatic test_conv();
        int base, dbase;
        bit ok;
        int exp_a [4];
        exp_a = '{0, 1, 6, 7};
        fill_ones();
        layer = 3'd0; cfg_in_w = 6'd6; cfg_n_out = 10'd4;
        base = fa_n1; dbase = done_cnt1;
        pulse_start(1);
        for (int k = 0; k < 4; k++) begin
            wait_valid(1, ok);
            total++;
            if (ok !== 1'b1) begin bad++; $display("FAIL conv_timeout out=%0d got=no_valid exp=valid", k); end
            total++;
            if (if1.res_data !== 32'd25) begin
                bad++; $display("FAIL conv_data out=%0d got=%0d exp=25", k, $signed(if1.res_data));
            end
            total++;
            if (if1.res_idx !== 10'(k)) begin
                bad++; $display("FAIL conv_idx got=%0d exp=%0d", if1.res_idx, k);
            end
            total++;
            if (en_cnt1 !== 25) begin
                bad++; $display("FAIL conv_en_cnt out=%0d got=%0d exp=25", k, en_cnt1);
            end
            total++;
            if (fa1[(base + k) % 64] !== 12'(exp_a[k])) begin
                bad++; $display("FAIL conv_first_a out=%0d got=%0d exp=%0d", k, fa1[(base + k) % 64], exp_a[k]);
            end
            accept(1);
        end
        wait_done(1, ok);
        @(negedge clk);
        total++;
        if (done_cnt1 - dbase !== 1) begin
            bad++; $display("FAIL conv_done_cnt got=%0d exp=1", done_cnt1 - dbase);
        end
        total++;
        if (busy1 !== 1'b0) begin bad++; $display("FAIL conv_busy_end got=%b exp=0", busy1); end
    endtask

    task automatic test_fc();
        int base;
        bit ok;
        for (int i = 0; i < 192; i++) amem[i] = 16'd2;
        for (int i = 0; i < 384; i++) wmem[i] = 16'hFFFD;
        layer = 3'd2; cfg_n_out = 10'd2;
        base = fa_n1;
        pulse_start(1);
        for (int k = 0; k < 2; k++) begin
            wait_valid(1, ok);
            total++;
            if (ok !== 1'b1) begin bad++; $display("FAIL fc_timeout out=%0d got=no_valid exp=valid", k); end
            total++;
            if (if1.res_data !== 32'hFFFF_FB80) begin
                bad++; $display("FAIL fc_data out=%0d got=%0d exp=-1152", k, $signed(if1.res_data));
            end
            total++;
            if (en_cnt1 !== 192) begin
                bad++; $display("FAIL fc_en_cnt out=%0d got=%0d exp=192", k, en_cnt1);
            end
            total++;
            if (fw1[(base + k) % 64] !== 12'(192 * k)) begin
                bad++; $display("FAIL fc_first_w out=%0d got=%0d exp=%0d", k, fw1[(base + k) % 64], 192 * k);
            end
            accept(1);
        end
        wait_done(1, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL fc_done got=none exp=pulse"); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        logic [9:0]  i0;
        int rc;
        bit ok;
        fill_ones();
        layer = 3'd0; cfg_in_w = 6'd6; cfg_n_out = 10'd2;
        pulse_start(1);
        wait_valid(1, ok);
        d0 = if1.res_data; i0 = if1.res_idx; rc = rd_cnt1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (if1.res_valid !== 1'b1 || if1.res_data !== d0 || if1.res_idx !== i0 || rd_cnt1 !== rc) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%0d i=%0d rd=%0d exp v=1 d=%0d i=%0d rd=%0d",
                         c, if1.res_valid, if1.res_data, if1.res_idx, rd_cnt1, d0, i0, rc);
            end
        end
        total++;
        if (d0 !== 32'd25) begin bad++; $display("FAIL bp_data got=%0d exp=25", d0); end
        accept(1);
        wait_valid(1, ok);
        total++;
        if (ok !== 1'b1 || if1.res_idx !== 10'd1 || if1.res_data !== 32'd25) begin
            bad++; $display("FAIL bp_second got ok=%b i=%0d d=%0d exp ok=1 i=1 d=25", ok, if1.res_idx, if1.res_data);
        end
        accept(1);
        wait_done(1, ok);
        @(negedge clk);
    endtask

    task automatic test_illegal_zero();
        int rc, dbase;
        layer = 3'd5; cfg_n_out = 10'd4;
        pulse_start(1);
        total++;
        if (err1 !== 1'b1 || busy1 !== 1'b0) begin
            bad++; $display("FAIL illegal_err got err=%b busy=%b exp err=1 busy=0", err1, busy1);
        end
        @(negedge clk);
        total++;
        if (err1 !== 1'b0 || busy1 !== 1'b0) begin
            bad++; $display("FAIL illegal_pulse got err=%b busy=%b exp err=0 busy=0", err1, busy1);
        end
        layer = 3'd0; cfg_n_out = 10'd0;
        rc = rd_cnt1; dbase = done_cnt1;
        pulse_start(1);
        total++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) begin
            bad++; $display("FAIL zero_c1 got done=%b busy=%b exp done=0 busy=1", done1, busy1);
        end
        @(negedge clk);
        total++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            bad++; $display("FAIL zero_c2 got done=%b busy=%b exp done=1 busy=0", done1, busy1);
        end
        @(negedge clk);
        total++;
        if (done1 !== 1'b0 || rd_cnt1 !== rc || done_cnt1 - dbase !== 1) begin
            bad++; $display("FAIL zero_c3 got done=%b rd=%0d dcnt=%0d exp done=0 rd=%0d dcnt=1",
                            done1, rd_cnt1 - rc, done_cnt1 - dbase, 0);
        end
    endtask

    task automatic test_reset_mid();
        int dbase;
        bit ok;
        fill_ones();
        layer = 3'd0; cfg_in_w = 6'd6; cfg_n_out = 10'd4;
        pulse_start(1);
        wait_valid(1, ok);
        accept(1);
        repeat (4) @(negedge clk);
        total++;
        if (if1.rd_en !== 1'b1) begin bad++; $display("FAIL mid_fetch got rd_en=%b exp=1", if1.rd_en); end
        dbase = done_cnt1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({busy1, done1, err1, if1.rd_en, if1.mac_en, if1.mac_clr, if1.res_valid} !== 7'b0 ||
            {if1.w_addr, if1.a_addr, if1.mac_a, if1.mac_b, if1.res_data, if1.res_idx} !== '0) begin
            bad++;
            $display("FAIL mid_reset got ctl=%b wa=%h aa=%h ma=%h mb=%h exp all 0",
                     {busy1, done1, err1, if1.rd_en, if1.mac_en, if1.mac_clr, if1.res_valid},
                     if1.w_addr, if1.a_addr, if1.mac_a, if1.mac_b);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (done_cnt1 !== dbase || busy1 !== 1'b0) begin
            bad++; $display("FAIL mid_no_done got dcnt=%0d busy=%b exp dcnt=0 busy=0", done_cnt1 - dbase, busy1);
        end
        cfg_n_out = 10'd1;
        pulse_start(1);
        wait_valid(1, ok);
        total++;
        if (ok !== 1'b1 || if1.res_data !== 32'd25 || if1.res_idx !== 10'd0) begin
            bad++; $display("FAIL mid_restart got ok=%b d=%0d i=%0d exp ok=1 d=25 i=0", ok, if1.res_data, if1.res_idx);
        end
        accept(1);
        wait_done(1, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL mid_restart_done got=none exp=pulse"); end
        @(negedge clk);
    endtask

    task automatic test_lat2();
        int golden [4];
        int av, wv, dbase;
        bit ok;
        for (int i = 0; i < 64; i++) amem[i] = 16'($urandom);
        for (int i = 0; i < 25; i++) wmem[i] = 16'($urandom);
        for (int o = 0; o < 4; o++) begin
            golden[o] = 0;
            for (int ky = 0; ky < 5; ky++)
                for (int kx = 0; kx < 5; kx++) begin
                    av = int'($signed(amem[(o / 2 + ky) * 6 + (o % 2) + kx]));
                    wv = int'($signed(wmem[ky * 5 + kx]));
                    golden[o] = golden[o] + av * wv;
                end
        end
        layer = 3'd1; cfg_in_w = 6'd6; cfg_n_out = 10'd4;
        dbase = done_cnt2;
        pulse_start(2);
        for (int k = 0; k < 4; k++) begin
            wait_valid(2, ok);
            total++;
            if (ok !== 1'b1) begin bad++; $display("FAIL lat2_timeout out=%0d got=no_valid exp=valid", k); end
            total++;
            if (if2.res_data !== 32'(golden[k]) || if2.res_idx !== 10'(k)) begin
                bad++; $display("FAIL lat2_data out=%0d got d=%0d i=%0d exp d=%0d i=%0d", k,
                                $signed(if2.res_data), if2.res_idx, golden[k], k);
            end
            total++;
            if (en_cnt2 !== 25) begin
                bad++; $display("FAIL lat2_en_cnt out=%0d got=%0d exp=25", k, en_cnt2);
            end
            accept(2);
        end
        wait_done(2, ok);
        @(negedge clk);
        total++;
        if (done_cnt2 - dbase !== 1 || busy2 !== 1'b0) begin
            bad++; $display("FAIL lat2_done got dcnt=%0d busy=%b exp dcnt=1 busy=0", done_cnt2 - dbase, busy2);
        end
    endtask

    initial begin
        if1.res_ready = 1'b0;
        if2.res_ready = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            wmem[i] = 16'd1;
            amem[i] = 16'd1;
        end
        test_reset();
        test_conv();
        test_fc();
        test_backpressure();
        test_illegal_zero();
        test_reset_mid();
        test_lat2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
